// File: rtl/memory_bus_6s4x_if.sv
// CPU-side nibble bus of memory_bus_6s4x: address, write strobe/data and
// the registered read nibble returned by the bus.
interface memory_bus_6s4x_if;
  logic [11:0] memory_addr;
  logic        memory_write_en;
  logic [3:0]  memory_write_data;
  logic [3:0]  memory_read_data;

  modport master (
    output memory_addr,
    output memory_write_en,
    output memory_write_data,
    input  memory_read_data
  );

  modport slave (
    input  memory_addr,
    input  memory_write_en,
    input  memory_write_data,
    output memory_read_data
  );
endinterface

// File: rtl/memory_bus_6s4x.sv
// Nibble memory bus: RAM, two VRAM display segments with an LCD scanout port,
// and an I/O page holding the interrupt factor/mask registers.
module memory_bus_6s4x #(
  parameter int          RAM_DEPTH    = 640,
  parameter int          SEG_LEN      = 80,
  parameter logic [11:0] SEG_LO_BASE  = 12'hE00,
  parameter logic [11:0] SEG_HI_BASE  = 12'hE80,
  parameter int          INT_CHANNELS = 3
) (
  input  logic                      clk,
  input  logic                      reset_n,
  memory_bus_6s4x_if.slave          bus,
  input  logic [7:0]                video_addr,
  output logic [3:0]                video_data,
  input  logic [4*INT_CHANNELS-1:0] int_event,
  output logic                      interrupt_req
);

  localparam int          RAM_AW     = (RAM_DEPTH > 1) ? $clog2(RAM_DEPTH) : 1;
  localparam int          FW         = 4 * INT_CHANNELS;
  localparam logic [11:0] RAM_END    = 12'(RAM_DEPTH);
  localparam logic [11:0] LO_END     = 12'(SEG_LO_BASE + SEG_LEN);
  localparam logic [11:0] HI_END     = 12'(SEG_HI_BASE + SEG_LEN);
  localparam logic [8:0]  VID_LO_END = 9'(SEG_LEN);
  localparam logic [8:0]  VID_HI_END = 9'(128 + SEG_LEN);

  typedef enum logic [1:0] {SRC_ZERO, SRC_RAM, SRC_VRAM, SRC_IO} src_e;

  logic [11:0]       addr;
  logic              wr_en;
  logic              rd_en;
  logic [3:0]        wdata;
  logic              sel_ram;
  logic              sel_vram;
  logic              sel_io;
  logic [RAM_AW-1:0] ram_idx;
  logic [7:0]        vram_idx;
  logic [2:0]        io_ch;
  logic              ch_ok;
  logic              is_flag;
  logic              is_mask;
  logic              is_stat;
  logic [3:0]        io_rdata;
  logic              vid_ok;

  logic [3:0]        ram_q  [RAM_DEPTH];
  logic [3:0]        vram_q [256];
  logic [3:0]        ram_rd_q;
  logic [3:0]        vram_rd_q;
  logic [3:0]        vid_raw_q;

  logic [FW-1:0]     flags_q, flags_d;
  logic [FW-1:0]     mask_q,  mask_d;
  logic              irq_q,   irq_d;
  src_e              src_q,   src_d;
  logic [3:0]        io_rd_q, io_rd_d;
  logic              vid_ok_q;

  assign addr  = bus.memory_addr;
  assign wr_en = bus.memory_write_en;
  assign rd_en = ~bus.memory_write_en;
  assign wdata = bus.memory_write_data;

  always_comb begin
    sel_ram  = (addr < RAM_END);
    sel_vram = ~sel_ram &&
               (((addr >= SEG_LO_BASE) && (addr < LO_END)) ||
                ((addr >= SEG_HI_BASE) && (addr < HI_END)));
    sel_io   = ~sel_ram && ~sel_vram && (addr[11:8] == 4'hF);
    ram_idx  = addr[RAM_AW-1:0];
    vram_idx = 8'(addr - SEG_LO_BASE);
    io_ch    = addr[2:0];
    ch_ok    = (addr[3:0] < 4'(INT_CHANNELS));
    is_flag  = sel_io && (addr[7:4] == 4'h0) && ch_ok;
    is_mask  = sel_io && (addr[7:4] == 4'h1) && ch_ok;
    is_stat  = sel_io && (addr[7:0] == 8'h20);
    // Scanout indexes between the segments hold nothing ever written: read as zero
    vid_ok   = ({1'b0, video_addr} < VID_LO_END) ||
               ((video_addr >= 8'd128) && ({1'b0, video_addr} < VID_HI_END));
  end

  always_comb begin
    io_rdata = 4'h0;
    if (is_flag)      io_rdata = flags_q[{io_ch, 2'b00} +: 4];
    else if (is_mask) io_rdata = mask_q[{io_ch, 2'b00} +: 4];
    else if (is_stat) io_rdata = {3'b000, irq_q};
  end

  // A clearing read and a new event on the same bit: the event wins
  always_comb begin
    flags_d = flags_q;
    if (rd_en && is_flag) flags_d[{io_ch, 2'b00} +: 4] = 4'h0;
    flags_d = flags_d | int_event;
    mask_d = mask_q;
    if (wr_en && is_mask) mask_d[{io_ch, 2'b00} +: 4] = wdata;
    irq_d = |(flags_d & mask_d);
  end

  always_comb begin
    src_d   = src_q;
    io_rd_d = io_rd_q;
    if (rd_en) begin
      io_rd_d = io_rdata;
      if (sel_ram)       src_d = SRC_RAM;
      else if (sel_vram) src_d = SRC_VRAM;
      else if (sel_io)   src_d = SRC_IO;
      else               src_d = SRC_ZERO;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      flags_q  <= '0;
      mask_q   <= '0;
      irq_q    <= 1'b0;
      src_q    <= SRC_ZERO;
      io_rd_q  <= 4'h0;
      vid_ok_q <= 1'b0;
    end else begin
      flags_q  <= flags_d;
      mask_q   <= mask_d;
      irq_q    <= irq_d;
      src_q    <= src_d;
      io_rd_q  <= io_rd_d;
      vid_ok_q <= vid_ok;
    end
  end

  // Storage arrays and their read registers stay unreset so they map to block RAM
  always_ff @(posedge clk) begin
    if (wr_en && sel_ram) ram_q[ram_idx] <= wdata;
    if (rd_en && sel_ram) ram_rd_q <= ram_q[ram_idx];
  end

  always_ff @(posedge clk) begin
    if (wr_en && sel_vram) vram_q[vram_idx] <= wdata;
    if (rd_en && sel_vram) vram_rd_q <= vram_q[vram_idx];
    vid_raw_q <= vram_q[video_addr];
  end

  always_comb begin
    case (src_q)
      SRC_RAM:  bus.memory_read_data = ram_rd_q;
      SRC_VRAM: bus.memory_read_data = vram_rd_q;
      SRC_IO:   bus.memory_read_data = io_rd_q;
      default:  bus.memory_read_data = 4'h0;
    endcase
  end

  assign video_data    = vid_ok_q ? vid_raw_q : 4'h0;
  assign interrupt_req = irq_q;

endmodule

// File: tb/tb_memory_bus_6s4x.sv
// Scoreboard bench for memory_bus_6s4x: expected read nibbles are queued as
// each access is driven and checked when the registered output appears.
module tb_memory_bus_6s4x;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [7:0]  video_addr = 8'h00;
  logic [3:0]  video_data;
  logic [11:0] int_event = '0;
  logic        interrupt_req;

  memory_bus_6s4x_if bus ();

  memory_bus_6s4x dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .bus           (bus),
    .video_addr    (video_addr),
    .video_data    (video_data),
    .int_event     (int_event),
    .interrupt_req (interrupt_req)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      tag;
    logic [3:0] exp;
  } exp_t;

  exp_t rd_q[$];
  exp_t vd_q[$];
  int   n_chk = 0;
  int   n_bad = 0;

  task automatic chk(input string tag, input logic [3:0] got, input logic [3:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic pop_rd();
    exp_t e;
    if (rd_q.size() == 0) begin
      chk("rd_scoreboard_empty", 4'h1, 4'h0);
    end else begin
      e = rd_q.pop_front();
      chk(e.tag, bus.memory_read_data, e.exp);
    end
  endtask

  task automatic pop_vd();
    exp_t e;
    if (vd_q.size() == 0) begin
      chk("vid_scoreboard_empty", 4'h1, 4'h0);
    end else begin
      e = vd_q.pop_front();
      chk(e.tag, video_data, e.exp);
    end
  endtask

  // Idle cycles read an unmapped address so no I/O side effects occur
  task automatic bus_idle();
    bus.memory_addr       = 12'h7FF;
    bus.memory_write_en   = 1'b0;
    bus.memory_write_data = 4'h0;
  endtask

  task automatic cpu_write(input logic [11:0] a, input logic [3:0] d);
    @(negedge clk);
    bus.memory_addr       = a;
    bus.memory_write_en   = 1'b1;
    bus.memory_write_data = d;
    @(posedge clk);
    #1;
    bus_idle();
  endtask

  task automatic cpu_read(input logic [11:0] a, input logic [3:0] exp, input string tag);
    @(negedge clk);
    bus.memory_addr     = a;
    bus.memory_write_en = 1'b0;
    rd_q.push_back('{tag, exp});
    @(posedge clk);
    #1;
    bus_idle();
    pop_rd();
  endtask

  task automatic vid_read(input logic [7:0] va, input logic [3:0] exp, input string tag);
    @(negedge clk);
    video_addr = va;
    vd_q.push_back('{tag, exp});
    @(posedge clk);
    #1;
    pop_vd();
  endtask

  task automatic pulse(input logic [11:0] ev);
    @(negedge clk);
    int_event = ev;
    @(posedge clk);
    #1;
    int_event = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: got=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    bus_idle();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_rdata", bus.memory_read_data, 4'h0);
    chk("rst_video", video_data, 4'h0);
    chk("rst_irq", {3'b000, interrupt_req}, 4'h0);
    @(negedge clk);
    reset_n = 1'b1;

    // RAM
    cpu_write(12'h000, 4'h5);
    cpu_write(12'h27F, 4'hA);
    cpu_read(12'h000, 4'h5, "ram_000");
    cpu_read(12'h27F, 4'hA, "ram_27f");
    cpu_write(12'h001, 4'h6);
    chk("hold_on_write", bus.memory_read_data, 4'hA);
    cpu_read(12'h280, 4'h0, "unmapped_280");
    cpu_read(12'h001, 4'h6, "ram_001");

    // VRAM
    cpu_write(12'hE4F, 4'h3);
    cpu_write(12'hE80, 4'hC);
    vid_read(8'h4F, 4'h3, "vid_4f");
    vid_read(8'h80, 4'hC, "vid_80");
    cpu_write(12'hE50, 4'h7);
    vid_read(8'h50, 4'h0, "vid_gap_50");
    cpu_read(12'hE50, 4'h0, "cpu_gap_e50");
    cpu_read(12'hE80, 4'hC, "cpu_vram_e80");
    @(negedge clk);
    bus.memory_addr       = 12'hE4F;
    bus.memory_write_en   = 1'b1;
    bus.memory_write_data = 4'h9;
    video_addr            = 8'h4F;
    vd_q.push_back('{"vid_same_cycle_old", 4'h3});
    @(posedge clk);
    #1;
    bus_idle();
    pop_vd();
    vid_read(8'h4F, 4'h9, "vid_after_write");

    // Interrupt via mask then event
    cpu_write(12'hF10, 4'h2);
    chk("irq_mask_only", {3'b000, interrupt_req}, 4'h0);
    pulse(12'h002);
    chk("irq_after_event", {3'b000, interrupt_req}, 4'h1);
    cpu_read(12'hF20, 4'h1, "status_irq");
    cpu_read(12'hF10, 4'h2, "mask_readback");
    cpu_read(12'hF00, 4'h2, "flag_read");
    chk("irq_after_clear", {3'b000, interrupt_req}, 4'h0);
    cpu_read(12'hF00, 4'h0, "flag_reread");
    cpu_read(12'hF20, 4'h0, "status_clear");

    // Event coinciding with clearing read of the same channel
    @(negedge clk);
    bus.memory_addr     = 12'hF01;
    bus.memory_write_en = 1'b0;
    int_event           = 12'h010;
    rd_q.push_back('{"flag_race_read", 4'h0});
    @(posedge clk);
    #1;
    bus_idle();
    int_event = '0;
    pop_rd();
    cpu_read(12'hF01, 4'h1, "flag_race_kept");
    cpu_read(12'hF01, 4'h0, "flag_race_cleared");
    chk("irq_unmasked_ch1", {3'b000, interrupt_req}, 4'h0);

    // Undefined I/O addresses
    cpu_write(12'hF13, 4'hF);
    cpu_read(12'hF13, 4'h0, "mask_ch3_absent");
    cpu_read(12'hF03, 4'h0, "flag_ch3_absent");
    cpu_write(12'hF00, 4'hF);
    cpu_read(12'hF00, 4'h0, "flag_write_ignored");

    // Masked event, then unmask
    cpu_write(12'hF10, 4'h0);
    pulse(12'h001);
    chk("irq_masked", {3'b000, interrupt_req}, 4'h0);
    cpu_write(12'hF10, 4'h1);
    chk("irq_after_unmask", {3'b000, interrupt_req}, 4'h1);
    pulse(12'h800);

    // Reset mid-stream with a read in flight
    @(negedge clk);
    bus.memory_addr     = 12'h000;
    bus.memory_write_en = 1'b0;
    video_addr          = 8'h4F;
    @(posedge clk);
    #1;
    chk("pre_reset_rdata", bus.memory_read_data, 4'h5);
    chk("pre_reset_video", video_data, 4'h9);
    #2;
    reset_n = 1'b0;
    #1;
    chk("mid_reset_rdata", bus.memory_read_data, 4'h0);
    chk("mid_reset_video", video_data, 4'h0);
    chk("mid_reset_irq", {3'b000, interrupt_req}, 4'h0);
    bus_idle();
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    cpu_read(12'hF00, 4'h0, "post_reset_flag0");
    cpu_read(12'hF10, 4'h0, "post_reset_mask0");
    cpu_read(12'hF02, 4'h0, "post_reset_flag2");
    chk("post_reset_irq", {3'b000, interrupt_req}, 4'h0);
    cpu_read(12'h000, 4'h5, "post_reset_ram");
    vid_read(8'h4F, 4'h9, "post_reset_vid");

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
